seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 128 ++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider: one quotient bit per clock, MSB first,
// with a sign-fix step, a one-cycle early exit for divide-by-zero, and result registers that hold between operations.
module seq_divider #(
  parameter int DVD_W = 8,
  parameter int DVS_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [DVD_W-1:0] dividendin,
  input  logic [DVS_W-1:0] divisorin,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             dbz,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  localparam int CNT_W = $clog2(DVD_W + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Handshake: start is sampled only in IDLE. busy is high in RUN and FIX, and
  // also in DONE on the divide-by-zero path. done is a one-cycle pulse in DONE;
  // the result outputs are valid from then until the next operation completes.

  logic [1:0]       state;
  logic [DVD_W-1:0] dvd_sh;    // dividend bits shift out the top, quotient bits shift in at the bottom
  logic [DVS_W-1:0] dvs_mag;
  logic [DVS_W:0]   rem_w;
  logic [CNT_W-1:0] cnt;
  logic             q_neg;
  logic             r_neg;
  logic             ovf_p;
  logic             dbz_path;

  logic [DVD_W-1:0] dvd_abs;
  logic [DVS_W-1:0] dvs_abs;
  logic [DVS_W:0]   rem_shift;
  logic [DVS_W:0]   trial;
  logic             fits;
  logic [DVS_W-1:0] rem_mag;
  logic             is_min_dvd;

  always_comb begin
    dvd_abs    = dividendin;
    dvs_abs    = divisorin;
    if (signed_mode && dividendin[DVD_W-1]) dvd_abs = -dividendin;
    if (signed_mode && divisorin[DVS_W-1])  dvs_abs = -divisorin;
    is_min_dvd = (dividendin == {1'b1, {(DVD_W-1){1'b0}}});
    rem_shift  = {rem_w[DVS_W-1:0], dvd_sh[DVD_W-1]};
    trial      = rem_shift - {1'b0, dvs_mag};
    // A set top bit in the working remainder means the shifted value already exceeds the divisor.
    fits       = rem_w[DVS_W] | (rem_shift >= {1'b0, dvs_mag});
    rem_mag    = rem_w[DVS_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dvd_sh    <= '0;
      dvs_mag   <= '0;
      rem_w     <= '0;
      cnt       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      ovf_p     <= 1'b0;
      dbz_path  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd_sh  <= dvd_abs;
            dvs_mag <= dvs_abs;
            rem_w   <= '0;
            cnt     <= '0;
            q_neg   <= signed_mode & (dividendin[DVD_W-1] ^ divisorin[DVS_W-1]);
            r_neg   <= signed_mode & dividendin[DVD_W-1];
            ovf_p   <= signed_mode & is_min_dvd & (&divisorin);
            if (divisorin == '0) begin
              state     <= DONE;
              dbz_path  <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
              dbz       <= 1'b1;
              ovf       <= 1'b0;
            end else begin
              state    <= RUN;
              dbz_path <= 1'b0;
            end
          end
        end
        RUN: begin
          dvd_sh <= {dvd_sh[DVD_W-2:0], fits};
          rem_w  <= fits ? trial : rem_shift;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(DVD_W - 1)) state <= FIX;
        end
        FIX: begin
          quotient  <= q_neg ? -dvd_sh : dvd_sh;
          remainder <= r_neg ? -rem_mag : rem_mag;
          dbz       <= 1'b0;
          ovf       <= ovf_p;
          state     <= DONE;
        end
        default: begin
          dbz_path <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign done      = (state == DONE);
  assign busy      = (state == RUN) | (state == FIX) | ((state == DONE) & dbz_path);
  assign state_dbg = state;

endmodule
